pad_turbo: RTL and testbench

- Per-player input conditioning stage directly upstream of the multitap; its outputs drive the P1..P4 button inputs.
- Takes four raw active-high 12-bit button vectors from the host HPS/joystick layer.
- Applies, in this order: SOCD cleaning on the D-pad, per-button turbo (autofire) timed by video frames, and 3-button masking.
- Produces registered, glitch-free button vectors for the multitap.

---
 rtl/pad_pkg.sv | 35 +++
 rtl/pad_turbo_player.sv | 106 ++++++++++
 rtl/pad_turbo.sv | 96 +++++++++
 tb/tb_pad_turbo.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared types and constants for the per-player pad conditioning stage.
package pad_pkg;

    typedef logic [11:0] pad_t;

    localparam int unsigned BTN_RIGHT = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_UP    = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_C     = 6;
    localparam int unsigned BTN_START = 7;
    localparam int unsigned BTN_MODE  = 8;
    localparam int unsigned BTN_X     = 9;
    localparam int unsigned BTN_Y     = 10;
    localparam int unsigned BTN_Z     = 11;

    localparam logic [1:0] RATE_OFF       = 2'd0;
    localparam logic [1:0] RATE_CODE_SLOW = 2'd1;
    localparam logic [1:0] RATE_CODE_MED  = 2'd2;
    localparam logic [1:0] RATE_CODE_FAST = 2'd3;

    typedef enum logic [1:0] {
        SOCD_PASS    = 2'd0,
        SOCD_NEUTRAL = 2'd1,
        SOCD_LAST    = 2'd2
    } socd_e;

    // Frame counters compare against half-1, which must fit in two bits.
    function automatic logic [1:0] rate_half_m1(input int unsigned half);
        return 2'(half - 1);
    endfunction

endpackage

// File: rtl/pad_turbo_player.sv
// One player's stage 2: SOCD cleaning, per-button turbo and 3-button masking.
module pad_turbo_player
    import pad_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       j3but_i,
    input  logic [1:0] socd_i,
    input  logic       turbo_en_i,
    input  logic [1:0] half_m1_i,
    input  pad_t       joy_i,
    input  pad_t       mask_i,
    output pad_t       pad_o
);

    pad_t             prev_q;
    pad_t             press;
    pad_t             clean;
    logic             hist_ud_q, hist_ud_d;
    logic             hist_lr_q, hist_lr_d;
    logic [11:0]      phase_q, phase_d;
    logic [11:0][1:0] cnt_q, cnt_d;
    pad_t             pad_q, pad_d;

    // pair[1] is the member that wins a simultaneous press (UP or RIGHT).
    function automatic logic [1:0] socd_pair(input logic [1:0] mode, input logic [1:0] pair,
                                             input logic hist_hi);
        logic [1:0] res;
        res = pair;
        if (pair == 2'b11) begin
            case (mode)
                SOCD_PASS: res = pair;
                SOCD_LAST: res = {hist_hi, ~hist_hi};
                default:   res = 2'b00;
            endcase
        end
        return res;
    endfunction

    always_comb begin
        press     = joy_i & ~prev_q;
        hist_ud_d = hist_ud_q;
        hist_lr_d = hist_lr_q;
        if (press[BTN_UP]) begin
            hist_ud_d = 1'b1;
        end else if (press[BTN_DOWN]) begin
            hist_ud_d = 1'b0;
        end
        if (press[BTN_RIGHT]) begin
            hist_lr_d = 1'b1;
        end else if (press[BTN_LEFT]) begin
            hist_lr_d = 1'b0;
        end
        clean = joy_i;
        {clean[BTN_UP], clean[BTN_DOWN]} =
            socd_pair(socd_i, {joy_i[BTN_UP], joy_i[BTN_DOWN]}, hist_ud_d);
        {clean[BTN_RIGHT], clean[BTN_LEFT]} =
            socd_pair(socd_i, {joy_i[BTN_RIGHT], joy_i[BTN_LEFT]}, hist_lr_d);
    end

    always_comb begin
        for (int i = 0; i < 12; i++) begin
            phase_d[i] = 1'b1;
            cnt_d[i]   = 2'd0;
            // A press edge restarts the sequence, so a coincident tick is ignored.
            if (turbo_en_i && mask_i[i] && clean[i] && !press[i]) begin
                phase_d[i] = phase_q[i];
                cnt_d[i]   = cnt_q[i];
                if (tick_i) begin
                    if (cnt_q[i] >= half_m1_i) begin
                        phase_d[i] = ~phase_q[i];
                        cnt_d[i]   = 2'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 2'd1;
                    end
                end
            end
        end
        pad_d = clean & phase_d;
        if (j3but_i) begin
            pad_d[BTN_Z:BTN_MODE] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q    <= '0;
            hist_ud_q <= 1'b0;
            hist_lr_q <= 1'b0;
            phase_q   <= '0;
            cnt_q     <= '0;
            pad_q     <= '0;
        end else begin
            prev_q    <= joy_i;
            hist_ud_q <= hist_ud_d;
            hist_lr_q <= hist_lr_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            pad_q     <= pad_d;
        end
    end

    assign pad_o = pad_q;

endmodule

// File: rtl/pad_turbo.sv
// Four-player input conditioning: stage-1 input registers, frame tick and rate decode.
module pad_turbo
    import pad_pkg::*;
#(
    parameter int unsigned RATE_SLOW = 4,
    parameter int unsigned RATE_MED  = 2,
    parameter int unsigned RATE_FAST = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        VBLANK,
    input  logic        J3BUT,
    input  logic [1:0]  SOCD,
    input  logic [1:0]  TURBO_RATE,
    input  logic [11:0] JOY1,
    input  logic [11:0] JOY2,
    input  logic [11:0] JOY3,
    input  logic [11:0] JOY4,
    input  logic [11:0] TURBO1,
    input  logic [11:0] TURBO2,
    input  logic [11:0] TURBO3,
    input  logic [11:0] TURBO4,
    output logic [11:0] P1,
    output logic [11:0] P2,
    output logic [11:0] P3,
    output logic [11:0] P4
);

    pad_t       joy_d  [4];
    pad_t       mask_d [4];
    pad_t       joy_q  [4];
    pad_t       mask_q [4];
    pad_t       pad_w  [4];
    logic       vblank_q;
    logic       tick;
    logic       turbo_en;
    logic [1:0] half_m1;

    always_comb begin
        joy_d[0]  = JOY1;
        joy_d[1]  = JOY2;
        joy_d[2]  = JOY3;
        joy_d[3]  = JOY4;
        mask_d[0] = TURBO1;
        mask_d[1] = TURBO2;
        mask_d[2] = TURBO3;
        mask_d[3] = TURBO4;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vblank_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                joy_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            vblank_q <= VBLANK;
            for (int i = 0; i < 4; i++) begin
                joy_q[i]  <= joy_d[i];
                mask_q[i] <= mask_d[i];
            end
        end
    end

    always_comb begin
        tick     = VBLANK & ~vblank_q;
        turbo_en = (TURBO_RATE != RATE_OFF);
        case (TURBO_RATE)
            RATE_CODE_MED:  half_m1 = rate_half_m1(RATE_MED);
            RATE_CODE_FAST: half_m1 = rate_half_m1(RATE_FAST);
            default:        half_m1 = rate_half_m1(RATE_SLOW);
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_player
        pad_turbo_player u_player (
            .clk_i      (CLK),
            .rst_i      (RESET),
            .tick_i     (tick),
            .j3but_i    (J3BUT),
            .socd_i     (SOCD),
            .turbo_en_i (turbo_en),
            .half_m1_i  (half_m1),
            .joy_i      (joy_q[g]),
            .mask_i     (mask_q[g]),
            .pad_o      (pad_w[g])
        );
    end

    assign P1 = pad_w[0];
    assign P2 = pad_w[1];
    assign P3 = pad_w[2];
    assign P4 = pad_w[3];

endmodule

// File: tb/tb_pad_turbo.sv
// Self-checking bench for pad_turbo: vector table, directed turbo sequences, random vs model.
module tb_pad_turbo;

    logic        clk = 1'b0;
    logic        RESET, VBLANK, J3BUT;
    logic [1:0]  SOCD, TURBO_RATE;
    logic [11:0] joy_tb [4];
    logic [11:0] trb_tb [4];
    wire  [11:0] JOY1 = joy_tb[0];
    wire  [11:0] JOY2 = joy_tb[1];
    wire  [11:0] JOY3 = joy_tb[2];
    wire  [11:0] JOY4 = joy_tb[3];
    wire  [11:0] TURBO1 = trb_tb[0];
    wire  [11:0] TURBO2 = trb_tb[1];
    wire  [11:0] TURBO3 = trb_tb[2];
    wire  [11:0] TURBO4 = trb_tb[3];
    logic [11:0] P1, P2, P3, P4;

    int n_tests = 0;
    int n_fail  = 0;

    pad_turbo dut (
        .CLK        (clk),
        .RESET      (RESET),
        .VBLANK     (VBLANK),
        .J3BUT      (J3BUT),
        .SOCD       (SOCD),
        .TURBO_RATE (TURBO_RATE),
        .JOY1       (JOY1),
        .JOY2       (JOY2),
        .JOY3       (JOY3),
        .JOY4       (JOY4),
        .TURBO1     (TURBO1),
        .TURBO2     (TURBO2),
        .TURBO3     (TURBO3),
        .TURBO4     (TURBO4),
        .P1         (P1),
        .P2         (P2),
        .P3         (P3),
        .P4         (P4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int gap);
        VBLANK = 1'b1;
        @(negedge clk);
        VBLANK = 1'b0;
        wait_n(gap - 1);
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            joy_tb[p] = '0;
            trb_tb[p] = '0;
        end
        VBLANK = 1'b0; J3BUT = 1'b0; SOCD = 2'd0; TURBO_RATE = 2'd0;
    endtask

    // Reference model: per-cycle behaviour from the button rules, with integer phase/counters.
    bit          m_on = 1'b0;
    logic [11:0] m_s1j [4];
    logic [11:0] m_s1t [4];
    logic [11:0] m_prev [4];
    logic [11:0] m_exp [4];
    bit          m_up_last [4];
    bit          m_right_last [4];
    int          m_ph [4][12];
    int          m_cnt [4][12];
    bit          m_vb;

    task automatic model_edge();
        logic [11:0] nj [4];
        logic [11:0] nt [4];
        logic [11:0] cur, edg, cl, outv;
        bit tick;
        int half;
        nj = '{JOY1, JOY2, JOY3, JOY4};
        nt = '{TURBO1, TURBO2, TURBO3, TURBO4};
        if (RESET) begin
            for (int p = 0; p < 4; p++) begin
                m_s1j[p] = '0; m_s1t[p] = '0; m_prev[p] = '0; m_exp[p] = '0;
                m_up_last[p] = 0; m_right_last[p] = 0;
                for (int b = 0; b < 12; b++) begin
                    m_ph[p][b] = 0; m_cnt[p][b] = 0;
                end
            end
            m_vb = 0;
            return;
        end
        tick = VBLANK && !m_vb;
        half = (TURBO_RATE == 2'd1) ? 4 : (TURBO_RATE == 2'd2) ? 2 : 1;
        for (int p = 0; p < 4; p++) begin
            cur = m_s1j[p];
            edg = cur & ~m_prev[p];
            if (edg[3]) m_up_last[p] = 1; else if (edg[2]) m_up_last[p] = 0;
            if (edg[0]) m_right_last[p] = 1; else if (edg[1]) m_right_last[p] = 0;
            cl = cur;
            if (cur[3] && cur[2] && SOCD != 2'd0) begin
                cl[3] = (SOCD == 2'd2) ? m_up_last[p] : 1'b0;
                cl[2] = (SOCD == 2'd2) ? !m_up_last[p] : 1'b0;
            end
            if (cur[0] && cur[1] && SOCD != 2'd0) begin
                cl[0] = (SOCD == 2'd2) ? m_right_last[p] : 1'b0;
                cl[1] = (SOCD == 2'd2) ? !m_right_last[p] : 1'b0;
            end
            for (int b = 0; b < 12; b++) begin
                if (TURBO_RATE != 2'd0 && m_s1t[p][b] && cl[b] && !edg[b]) begin
                    if (tick) begin
                        m_cnt[p][b]++;
                        if (m_cnt[p][b] >= half) begin
                            m_ph[p][b]  = 1 - m_ph[p][b];
                            m_cnt[p][b] = 0;
                        end
                    end
                end else begin
                    m_ph[p][b]  = 1;
                    m_cnt[p][b] = 0;
                end
                outv[b] = cl[b] && (m_ph[p][b] == 1);
            end
            if (J3BUT) outv[11:8] = 4'h0;
            m_exp[p]  = outv;
            m_prev[p] = cur;
            m_s1j[p]  = nj[p];
            m_s1t[p]  = nt[p];
        end
        m_vb = VBLANK;
    endtask

    always @(posedge clk) begin
        if (m_on) model_edge();
    end

    typedef struct {
        logic [1:0]  socd;
        logic        j3;
        logic [11:0] joy;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{2'd0, 1'b0, 12'h010, 12'h010};
        vecs[1]  = '{2'd1, 1'b0, 12'h00C, 12'h000};
        vecs[2]  = '{2'd1, 1'b0, 12'h003, 12'h000};
        vecs[3]  = '{2'd3, 1'b0, 12'h00F, 12'h000};
        vecs[4]  = '{2'd0, 1'b0, 12'h00F, 12'h00F};
        vecs[5]  = '{2'd2, 1'b0, 12'h00F, 12'h009};
        vecs[6]  = '{2'd1, 1'b0, 12'h0F5, 12'h0F5};
        vecs[7]  = '{2'd0, 1'b1, 12'hF00, 12'h000};
        vecs[8]  = '{2'd0, 1'b0, 12'hF00, 12'hF00};
        vecs[9]  = '{2'd0, 1'b1, 12'hFFF, 12'h0FF};
        vecs[10] = '{2'd2, 1'b1, 12'hABC, 12'h0B8};

        clear_inputs();
        RESET = 1'b1;
        wait_n(3);
        RESET = 1'b0;
        wait_n(1);
        check("reset", {P4, P3, P2, P1}, 48'h0);

        // Two-cycle latency.
        joy_tb[0] = 12'h010;
        wait_n(1);
        check("lat_1clk", {36'h0, P1}, 48'h0);
        wait_n(1);
        check("lat_2clk", {36'h0, P1}, 48'h010);
        check("lat_others", {12'h0, P4, P3, P2}, 48'h0);
        joy_tb[0] = '0;
        wait_n(3);

        for (int v = 0; v < 11; v++) begin
            SOCD = vecs[v].socd;
            J3BUT = vecs[v].j3;
            for (int p = 0; p < 4; p++) joy_tb[p] = '0;
            wait_n(3);
            for (int p = 0; p < 4; p++) joy_tb[p] = vecs[v].joy;
            wait_n(3);
            check($sformatf("vec%0d_p1", v), {36'h0, P1}, {36'h0, vecs[v].exp});
            check($sformatf("vec%0d_p2", v), {36'h0, P2}, {36'h0, vecs[v].exp});
            check($sformatf("vec%0d_p3", v), {36'h0, P3}, {36'h0, vecs[v].exp});
            check($sformatf("vec%0d_p4", v), {36'h0, P4}, {36'h0, vecs[v].exp});
        end
        clear_inputs();
        wait_n(3);

        // Last-input-wins: DOWN, then UP, then release UP.
        SOCD = 2'd2;
        joy_tb[1] = 12'h004;
        wait_n(5);
        check("socd2_down", {36'h0, P2}, 48'h004);
        joy_tb[1] = 12'h00C;
        wait_n(3);
        check("socd2_up_wins", {36'h0, P2}, 48'h008);
        joy_tb[1] = 12'h004;
        wait_n(3);
        check("socd2_release_up", {36'h0, P2}, 48'h004);
        clear_inputs();
        wait_n(3);

        // Slow turbo on P3 B: 4 frames on, 4 off, repeating.
        TURBO_RATE = 2'd1;
        trb_tb[2] = 12'h020;
        joy_tb[2] = 12'h020;
        wait_n(50);
        check("turbo_frame0", {47'h0, P3[5]}, 48'h1);
        for (int k = 1; k < 12; k++) begin
            VBLANK = 1'b1;
            @(negedge clk);
            VBLANK = 1'b0;
            wait_n(50);
            check($sformatf("turbo_frame%0d", k), {47'h0, P3[5]},
                  {47'h0, ((k / 4) % 2) == 0});
            wait_n(49);
        end
        joy_tb[2] = '0;
        wait_n(1);
        check("turbo_rel_1clk", {47'h0, P3[5]}, 48'h1);
        wait_n(1);
        check("turbo_rel_2clk", {47'h0, P3[5]}, 48'h0);
        wait_n(3);

        // Press edge coincident with a tick at the fast rate.
        TURBO_RATE = 2'd3;
        joy_tb[2] = 12'h020;
        wait_n(1);
        VBLANK = 1'b1;
        wait_n(1);
        VBLANK = 1'b0;
        check("coinc_start", {47'h0, P3[5]}, 48'h1);
        wait_n(97);
        check("coinc_frame_end", {47'h0, P3[5]}, 48'h1);
        VBLANK = 1'b1;
        wait_n(1);
        VBLANK = 1'b0;
        check("coinc_next_tick", {47'h0, P3[5]}, 48'h0);
        joy_tb[2] = '0;
        wait_n(3);

        // Rate change with counter at 2: next tick toggles.
        TURBO_RATE = 2'd1;
        joy_tb[2] = 12'h020;
        wait_n(3);
        pulse(10);
        pulse(10);
        check("ratechg_before", {47'h0, P3[5]}, 48'h1);
        TURBO_RATE = 2'd3;
        pulse(10);
        check("ratechg_after", {47'h0, P3[5]}, 48'h0);
        clear_inputs();
        wait_n(3);

        // Reset in the middle of a turbo off-phase.
        TURBO_RATE = 2'd1;
        trb_tb[0] = 12'h010;
        joy_tb[0] = 12'h010;
        joy_tb[1] = 12'h001;
        wait_n(3);
        repeat (4) pulse(10);
        check("rst_pre_off", {24'h0, P2, P1}, {24'h0, 12'h001, 12'h000});
        RESET = 1'b1;
        wait_n(1);
        check("rst_outputs_zero", {P4, P3, P2, P1}, 48'h0);
        wait_n(2);
        RESET = 1'b0;
        wait_n(1);
        check("rst_release_lat", {36'h0, P1}, 48'h0);
        wait_n(1);
        check("rst_release_a", {24'h0, P2, P1}, {24'h0, 12'h001, 12'h010});
        clear_inputs();
        wait_n(3);

        // Randomized run against the reference model.
        m_on = 1'b1;
        RESET = 1'b1;
        wait_n(2);
        RESET = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            check($sformatf("rand_c%0d", c), {P4, P3, P2, P1},
                  {m_exp[3], m_exp[2], m_exp[1], m_exp[0]});
            if ($urandom_range(0, 3) == 0) begin
                int p, b;
                p = $urandom_range(0, 3);
                b = $urandom_range(0, 11);
                joy_tb[p][b] = ~joy_tb[p][b];
            end
            if ($urandom_range(0, 63) == 0) trb_tb[$urandom_range(0, 3)] = 12'($urandom);
            if ($urandom_range(0, 255) == 0) TURBO_RATE = 2'($urandom);
            if ($urandom_range(0, 255) == 0) SOCD = 2'($urandom);
            if ($urandom_range(0, 255) == 0) J3BUT = 1'($urandom);
            VBLANK = ($urandom_range(0, 5) == 0);
            RESET = ($urandom_range(0, 999) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
